// File: rtl/otter_pc_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | otter_pc_gen_pkg : shared PC-source, mtvec-mode and FSM encodings    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package otter_pc_gen_pkg;

  localparam logic [1:0] PC_SRC_SEL_BR_JUMP   = 2'd0;
  localparam logic [1:0] PC_SRC_SEL_EPC       = 2'd1;
  localparam logic [1:0] PC_SRC_SEL_TRAP      = 2'd2;
  localparam logic [1:0] PC_SRC_SEL_RESET_VEC = 2'd3;

  localparam logic [1:0] MTVEC_MODE_DIRECT    = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED  = 2'd1;

  typedef enum logic [1:0] {
    OTTER_PCG_BOOT = 2'd0,
    OTTER_PCG_RUN  = 2'd1,
    OTTER_PCG_PEND = 2'd2
  } pcg_state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/otter_pc_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | otter_pc_gen_if : fetch request bus between PC generator and imem    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface otter_pc_gen_if #(
  parameter int XLEN = 32
);
  logic            o_req_valid;
  logic            i_req_ready;
  logic [XLEN-1:0] o_pc_addr;
  logic            o_flush;
  logic            o_misalign;
  logic [XLEN-1:0] o_misalign_addr;

  modport master (
    output o_req_valid, o_pc_addr, o_flush, o_misalign, o_misalign_addr,
    input  i_req_ready
  );

  modport slave (
    input  o_req_valid, o_pc_addr, o_flush, o_misalign, o_misalign_addr,
    output i_req_ready
  );
endinterface
`default_nettype wire

// File: rtl/otter_trap_vec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | otter_trap_vec : mtvec + cause -> trap handler address (combinational)|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module otter_trap_vec
  import otter_pc_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
) (
  input  wire logic [XLEN-1:0]    i_mtvec,
  input  wire logic               i_cause_int,
  input  wire logic [CAUSE_W-1:0] i_cause_code,
  output logic      [XLEN-1:0]    o_trap_tgt
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_offset;

  // Modes 2 and 3 are reserved and fall back to direct.
  always_comb begin
    w_base     = {i_mtvec[XLEN-1:2], 2'b00};
    w_offset   = {{(XLEN-CAUSE_W-2){1'b0}}, i_cause_code, 2'b00};
    o_trap_tgt = w_base;
    if ((i_mtvec[1:0] == MTVEC_MODE_VECTORED) && i_cause_int)
      o_trap_tgt = w_base + w_offset;
  end

endmodule
`default_nettype wire

// File: rtl/otter_pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | otter_pc_gen : OTTER fetch PC register, request handshake, redirects |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module otter_pc_gen
  import otter_pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              CAUSE_W   = 4
) (
  input  wire logic               i_clk,
  input  wire logic               i_rst_n,
  input  wire logic               i_redirect,
  input  wire logic [1:0]         i_redirect_sel,
  input  wire logic [XLEN-1:0]    i_br_tgt_addr,
  input  wire logic [XLEN-1:0]    i_epc_addr,
  input  wire logic [XLEN-1:0]    i_mtvec,
  input  wire logic               i_cause_int,
  input  wire logic [CAUSE_W-1:0] i_cause_code,
  otter_pc_gen_if.master          fetch
);

  pcg_state_e      r_state, w_state_nx;
  logic [XLEN-1:0] r_pc, w_pc_nx;
  logic [XLEN-1:0] r_pend, w_pend_nx;
  logic            r_flush, w_flush_nx;
  logic            r_misalign, w_misalign_nx;
  logic [XLEN-1:0] r_misalign_addr, w_misalign_addr_nx;

  logic [XLEN-1:0] w_trap_tgt;
  logic [XLEN-1:0] w_target;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_tgt_bad;
  logic            w_redir_ok;

  otter_trap_vec #(
    .XLEN    (XLEN),
    .CAUSE_W (CAUSE_W)
  ) u_trap_vec (
    .i_mtvec      (i_mtvec),
    .i_cause_int  (i_cause_int),
    .i_cause_code (i_cause_code),
    .o_trap_tgt   (w_trap_tgt)
  );

  always_comb begin
    w_target = i_br_tgt_addr;
    case (i_redirect_sel)
      PC_SRC_SEL_BR_JUMP:   w_target = i_br_tgt_addr;
      PC_SRC_SEL_EPC:       w_target = i_epc_addr;
      PC_SRC_SEL_TRAP:      w_target = w_trap_tgt;
      PC_SRC_SEL_RESET_VEC: w_target = RESET_VEC;
      default:              w_target = i_br_tgt_addr;
    endcase
  end

  assign w_req_valid = (r_state != OTTER_PCG_BOOT);
  assign w_accept    = w_req_valid & fetch.i_req_ready;
  assign w_tgt_bad   = i_redirect & is_misaligned(w_target[1:0]);
  assign w_redir_ok  = i_redirect & ~w_tgt_bad;

  // A rejected (misaligned) redirect is reported but otherwise invisible.
  always_comb begin
    w_state_nx         = r_state;
    w_pc_nx            = r_pc;
    w_pend_nx          = r_pend;
    w_flush_nx         = 1'b0;
    w_misalign_nx      = w_tgt_bad;
    w_misalign_addr_nx = w_tgt_bad ? w_target : r_misalign_addr;
    case (r_state)
      OTTER_PCG_BOOT: begin
        w_state_nx = OTTER_PCG_RUN;
      end
      OTTER_PCG_RUN: begin
        if (w_accept) begin
          w_pc_nx    = w_redir_ok ? w_target : r_pc + XLEN'(4);
          w_flush_nx = w_redir_ok;
        end else if (w_redir_ok) begin
          w_pend_nx  = w_target;
          w_state_nx = OTTER_PCG_PEND;
        end
      end
      OTTER_PCG_PEND: begin
        if (w_accept) begin
          w_pc_nx    = w_redir_ok ? w_target : r_pend;
          w_flush_nx = 1'b1;
          w_state_nx = OTTER_PCG_RUN;
        end else if (w_redir_ok) begin
          w_pend_nx  = w_target;
        end
      end
      default: begin
        w_state_nx = OTTER_PCG_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= OTTER_PCG_BOOT;
      r_pc            <= RESET_VEC;
      r_pend          <= '0;
      r_flush         <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_state         <= w_state_nx;
      r_pc            <= w_pc_nx;
      r_pend          <= w_pend_nx;
      r_flush         <= w_flush_nx;
      r_misalign      <= w_misalign_nx;
      r_misalign_addr <= w_misalign_addr_nx;
    end
  end

  assign fetch.o_req_valid     = w_req_valid;
  assign fetch.o_pc_addr       = r_pc;
  assign fetch.o_flush         = r_flush;
  assign fetch.o_misalign      = r_misalign;
  assign fetch.o_misalign_addr = r_misalign_addr;

endmodule
`default_nettype wire

// File: tb/tb_otter_pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_otter_pc_gen : directed stimulus with queue-based scoreboard      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_otter_pc_gen;
  import otter_pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [1:0]  redirect_sel;
  logic [31:0] br_tgt_addr;
  logic [31:0] epc_addr;
  logic [31:0] mtvec;
  logic        cause_int;
  logic [3:0]  cause_code;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_acc[$];
  logic [31:0] q_flush[$];
  logic [31:0] q_mis[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;

  otter_pc_gen_if #(.XLEN(32)) bus ();

  otter_pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h0),
    .CAUSE_W   (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_redirect     (redirect),
    .i_redirect_sel (redirect_sel),
    .i_br_tgt_addr  (br_tgt_addr),
    .i_epc_addr     (epc_addr),
    .i_mtvec        (mtvec),
    .i_cause_int    (cause_int),
    .i_cause_code   (cause_code),
    .fetch          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, inout logic [31:0] q[$], input logic [31:0] act);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected event (value %h), required none", name, act);
    end else begin
      chk(name, act, q.pop_front());
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_addr_stable", bus.o_pc_addr, prev_addr);
      if (bus.o_req_valid && bus.i_req_ready)
        pop_chk("accept_addr", q_acc, bus.o_pc_addr);
      if (bus.o_flush)
        pop_chk("flush_pc", q_flush, bus.o_pc_addr);
      if (bus.o_misalign)
        pop_chk("misalign_addr", q_mis, bus.o_misalign_addr);
      prev_stall = bus.o_req_valid && !bus.i_req_ready;
      prev_addr  = bus.o_pc_addr;
    end
  end

  task automatic tick(input logic rdy);
    bus.i_req_ready = rdy;
    redirect        = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic rdy, input logic [1:0] sel);
    bus.i_req_ready = rdy;
    redirect        = 1'b1;
    redirect_sel    = sel;
    @(posedge clk);
    #1;
    redirect        = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    redirect        = 1'b0;
    redirect_sel    = PC_SRC_SEL_BR_JUMP;
    br_tgt_addr     = '0;
    epc_addr        = '0;
    mtvec           = '0;
    cause_int       = 1'b0;
    cause_code      = '0;
    bus.i_req_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",        bus.o_pc_addr,             32'h0);
    chk("rst_valid",     {31'b0, bus.o_req_valid},  32'h0);
    chk("rst_flush",     {31'b0, bus.o_flush},      32'h0);
    chk("rst_misalign",  {31'b0, bus.o_misalign},   32'h0);
    chk("rst_mis_addr",  bus.o_misalign_addr,       32'h0);

    rst_n = 1'b1;
    #1;
    chk("boot_valid", {31'b0, bus.o_req_valid}, 32'h0);
    tick(1'b1);
    chk("run_valid", {31'b0, bus.o_req_valid}, 32'h1);

    // Sequential fetch then an accepted branch
    q_acc.push_back(32'h0); q_acc.push_back(32'h4); q_acc.push_back(32'h8);
    tick(1'b1); tick(1'b1);
    br_tgt_addr = 32'h100;
    redir(1'b1, PC_SRC_SEL_BR_JUMP);
    q_acc.push_back(32'h100); q_flush.push_back(32'h100);
    tick(1'b1);
    q_acc.push_back(32'h104);
    br_tgt_addr = 32'h20;
    redir(1'b1, PC_SRC_SEL_BR_JUMP);
    q_flush.push_back(32'h20);

    // Stalled at 0x20: BR 0x200 then EPC 0x300, latest wins
    br_tgt_addr = 32'h200;
    redir(1'b0, PC_SRC_SEL_BR_JUMP);
    epc_addr = 32'h300;
    redir(1'b0, PC_SRC_SEL_EPC);
    tick(1'b0);
    q_acc.push_back(32'h20);
    tick(1'b1);
    q_acc.push_back(32'h300); q_flush.push_back(32'h300);
    tick(1'b1);

    // Traps: vectored interrupt, direct, reserved mode, vectored exception
    mtvec = 32'h1001; cause_int = 1'b1; cause_code = 4'd7;
    q_acc.push_back(32'h304);
    redir(1'b1, PC_SRC_SEL_TRAP);
    q_acc.push_back(32'h101C); q_flush.push_back(32'h101C);
    mtvec = 32'h1000;
    redir(1'b1, PC_SRC_SEL_TRAP);
    q_acc.push_back(32'h1000); q_flush.push_back(32'h1000);
    tick(1'b1);

    // Misaligned branch with accept: reported, PC keeps advancing
    br_tgt_addr = 32'h102;
    q_acc.push_back(32'h1004);
    redir(1'b1, PC_SRC_SEL_BR_JUMP);
    q_acc.push_back(32'h1008); q_mis.push_back(32'h102);
    tick(1'b1);
    q_acc.push_back(32'h100C);
    tick(1'b1);

    mtvec = 32'h2002; cause_int = 1'b1; cause_code = 4'd3;
    q_acc.push_back(32'h1010);
    redir(1'b1, PC_SRC_SEL_TRAP);
    q_acc.push_back(32'h2000); q_flush.push_back(32'h2000);
    tick(1'b1);
    mtvec = 32'h3001; cause_int = 1'b0; cause_code = 4'd5;
    q_acc.push_back(32'h2004);
    redir(1'b1, PC_SRC_SEL_TRAP);
    q_acc.push_back(32'h3000); q_flush.push_back(32'h3000);
    tick(1'b1);

    // Misaligned branch while stalled: one pulse, nothing buffered
    br_tgt_addr = 32'h3;
    redir(1'b0, PC_SRC_SEL_BR_JUMP);
    q_mis.push_back(32'h3);
    tick(1'b0);
    tick(1'b0);
    q_acc.push_back(32'h3004);
    tick(1'b1);

    // Address wrap
    br_tgt_addr = 32'hFFFF_FFF8;
    q_acc.push_back(32'h3008);
    redir(1'b1, PC_SRC_SEL_BR_JUMP);
    q_flush.push_back(32'hFFFF_FFF8);
    q_acc.push_back(32'hFFFF_FFF8); q_acc.push_back(32'hFFFF_FFFC);
    q_acc.push_back(32'h0);         q_acc.push_back(32'h4);
    repeat (4) tick(1'b1);

    // PEND with a new redirect in the accepting cycle
    br_tgt_addr = 32'h400;
    redir(1'b0, PC_SRC_SEL_BR_JUMP);
    br_tgt_addr = 32'h500;
    q_acc.push_back(32'h8);
    redir(1'b1, PC_SRC_SEL_BR_JUMP);
    q_acc.push_back(32'h500); q_flush.push_back(32'h500);
    tick(1'b1);
    q_acc.push_back(32'h504);
    redir(1'b1, PC_SRC_SEL_RESET_VEC);
    q_acc.push_back(32'h0); q_flush.push_back(32'h0);
    tick(1'b1);

    // Asynchronous reset while a redirect is pending
    br_tgt_addr = 32'h600;
    redir(1'b0, PC_SRC_SEL_BR_JUMP);
    chk("pend_pc", bus.o_pc_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc",    bus.o_pc_addr,            32'h0);
    chk("async_rst_valid", {31'b0, bus.o_req_valid}, 32'h0);
    chk("async_rst_flush", {31'b0, bus.o_flush},     32'h0);
    bus.i_req_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1);
    q_acc.push_back(32'h0); q_acc.push_back(32'h4);
    tick(1'b1); tick(1'b1);
    tick(1'b0); tick(1'b0);

    chk("acc_queue_drained",   q_acc.size(),   32'd0);
    chk("flush_queue_drained", q_flush.size(), 32'd0);
    chk("mis_queue_drained",   q_mis.size(),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
